// File: rtl/mul_shared.sv
// Purpose : one shift-add multiplier engine shared by two start/busy clients, round-robin arbitrated.
// Latency : uncontended busy_o lasts W+1 cycles (1 grant cycle + W iterations); a queued client waits one extra job.
// Backpres: start is only sampled while busy_o=0; an accepted request is held pending until the engine frees up.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cN_a_bi, cN_b_bi   [W-1:0]    client N operands, latched when a start is accepted
//   cN_start_i                    client N request strobe (ignored while cN_busy_o=1)
//   cN_busy_o                     client N request accepted, result not yet written
//   cN_y_bo          [2*W-1:0]    client N product, held until that client's next completion
//
// Build option: define MUL_SHARED_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier is zero (1..W iterations instead of always W). Products are identical.
module mul_shared #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [W-1:0]   c0_a_bi,
    input  logic [W-1:0]   c0_b_bi,
    input  logic           c0_start_i,
    output logic           c0_busy_o,
    output logic [2*W-1:0] c0_y_bo,
    input  logic [W-1:0]   c1_a_bi,
    input  logic [W-1:0]   c1_b_bi,
    input  logic           c1_start_i,
    output logic           c1_busy_o,
    output logic [2*W-1:0] c1_y_bo
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Per-client request side, index 0 = client 0, index 1 = client 1.
    logic [1:0][W-1:0]   a_in, b_in;
    logic [1:0]          start;
    logic [1:0][W-1:0]   a_lat, b_lat;
    logic [1:0]          busy;
    logic [1:0]          pend;       // accepted but not yet handed to the engine
    logic [1:0][2*W-1:0] y_q;

    // Shared engine.
    logic                gnt;        // client currently owning the engine
    logic                last;       // winner of the most recent contested grant
    logic                gnt_sel;
    logic                grant_fire;
    logic                done;
    logic                last_iter;
    logic [2*W-1:0]      mcand;
    logic [W-1:0]        mplier;
    logic [2*W-1:0]      acc;
    logic [2*W-1:0]      acc_nxt;
    logic [CW-1:0]       cnt;

    assign a_in  = {c1_a_bi, c0_a_bi};
    assign b_in  = {c1_b_bi, c0_b_bi};
    assign start = {c1_start_i, c0_start_i};

    assign c0_busy_o = busy[0];
    assign c1_busy_o = busy[1];
    assign c0_y_bo   = y_q[0];
    assign c1_y_bo   = y_q[1];

    // Tie goes to the client that lost the previous contest; otherwise the lone requester.
    always_comb begin
        gnt_sel = 1'b0;
        if (pend == 2'b11) begin
            gnt_sel = ~last;
        end else begin
            gnt_sel = pend[1];
        end
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef MUL_SHARED_EARLY_EXIT_EN
    // Stop once the multiplier bits still to be consumed after this step are all zero.
    assign last_iter = (cnt == CW'(W - 1)) || ((mplier >> 1) == '0);
`else
    assign last_iter = (cnt == CW'(W - 1));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pend) begin
                    state_nxt  = S_MUL;
                    grant_fire = 1'b1;
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy   <= '0;
            pend   <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            y_q    <= '0;
            last   <= 1'b1;
            gnt    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            // Request capture: only an idle client can be accepted, so a client
            // being granted or completing below is never written here on the same edge.
            for (int i = 0; i < 2; i++) begin
                if (start[i] && !busy[i]) begin
                    busy[i]  <= 1'b1;
                    pend[i]  <= 1'b1;
                    a_lat[i] <= a_in[i];
                    b_lat[i] <= b_in[i];
                end
            end

            if (grant_fire) begin
                pend[gnt_sel] <= 1'b0;
                gnt           <= gnt_sel;
                if (pend == 2'b11) begin
                    last <= gnt_sel;
                end
                mcand  <= {{W{1'b0}}, a_lat[gnt_sel]};
                mplier <= b_lat[gnt_sel];
                acc    <= '0;
                cnt    <= '0;
            end

            if (state == S_MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (done) begin
                    y_q[gnt]  <= acc_nxt;
                    busy[gnt] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_shared.sv
module tb_mul_shared;

    localparam int W = 8;
`ifdef MUL_SHARED_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   c0_a, c0_b, c1_a, c1_b;
    logic           c0_start, c1_start;
    logic           c0_busy, c1_busy;
    logic [2*W-1:0] c0_y, c1_y;

    always #5 clk = ~clk;

    mul_shared #(.W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .c0_a_bi    (c0_a),
        .c0_b_bi    (c0_b),
        .c0_start_i (c0_start),
        .c0_busy_o  (c0_busy),
        .c0_y_bo    (c0_y),
        .c1_a_bi    (c1_a),
        .c1_b_bi    (c1_b),
        .c1_start_i (c1_start),
        .c1_busy_o  (c1_busy),
        .c1_y_bo    (c1_y)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Jobs: a client request is accepted when that client is idle; the engine
    // takes one cycle to pick a job, then spends iters(b) cycles on it.
    bit             m_busy [2];
    bit             m_pend [2];
    logic [W-1:0]   m_a [2];
    logic [W-1:0]   m_b [2];
    logic [2*W-1:0] m_y [2];
    bit             m_eng;
    int             m_cli;
    int             m_rem;
    int             m_last;

    function automatic int iters(input logic [W-1:0] b);
        int n = 0;
        if (!EE) return W;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return (n == 0) ? 1 : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_a[i] = '0; m_b[i] = '0; m_y[i] = '0;
        end
        m_eng = 0; m_cli = 0; m_rem = 0; m_last = 1;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit old_busy [2];
        bit st [2];
        logic [W-1:0] ia [2];
        logic [W-1:0] ib [2];
        if (rst) begin
            model_reset();
            return;
        end
        old_busy = m_busy;
        st[0] = c0_start; st[1] = c1_start;
        ia[0] = c0_a; ia[1] = c1_a; ib[0] = c0_b; ib[1] = c1_b;
        if (m_eng) begin
            m_rem--;
            if (m_rem == 0) begin
                m_y[m_cli]    = (2*W)'(m_a[m_cli]) * (2*W)'(m_b[m_cli]);
                m_busy[m_cli] = 0;
                m_eng         = 0;
            end
        end else if (m_pend[0] || m_pend[1]) begin
            if (m_pend[0] && m_pend[1]) begin
                m_cli  = (m_last == 1) ? 0 : 1;
                m_last = m_cli;
            end else begin
                m_cli = m_pend[1] ? 1 : 0;
            end
            m_pend[m_cli] = 0;
            m_eng = 1;
            m_rem = iters(m_b[m_cli]);
        end
        for (int i = 0; i < 2; i++) begin
            if (!old_busy[i] && st[i]) begin
                m_busy[i] = 1; m_pend[i] = 1; m_a[i] = ia[i]; m_b[i] = ib[i];
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [W-1:0]   a0, b0, a1, b1;
        logic [1:0]     who;        // bit0: c0 starts, bit1: c1 starts
        logic [2*W-1:0] y0, y1;     // expected products after completion
        int             bz0, bz1;   // expected busy cycle counts
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n0, n1;
        bit fin;

        vecs[0] = '{8'd0,   8'd0,   8'd0,   8'd0,   2'b01, 16'd0,     16'd0,    EE ? 2 : 9, 0};
        vecs[1] = '{8'd255, 8'd255, 8'd0,   8'd0,   2'b01, 16'd65025, 16'd0,    9,          0};
        vecs[2] = '{8'd0,   8'd0,   8'd54,  8'd54,  2'b10, 16'd65025, 16'd2916, 0,          EE ? 7 : 9};
        vecs[3] = '{8'd12,  8'd13,  8'd200, 8'd3,   2'b11, 16'd156,   16'd600,  EE ? 5 : 9, EE ? 8 : 18};
        vecs[4] = '{8'd3,   8'd4,   8'd5,   8'd6,   2'b11, 16'd12,    16'd30,   EE ? 8 : 18, EE ? 4 : 9};
        vecs[5] = '{8'd0,   8'd0,   8'd1,   8'd255, 2'b10, 16'd12,    16'd255,  0,          9};
        vecs[6] = '{8'd255, 8'd1,   8'd0,   8'd0,   2'b01, 16'd255,   16'd255,  EE ? 2 : 9, 0};
        vecs[7] = '{8'd54,  8'd2,   8'd0,   8'd0,   2'b01, 16'd108,   16'd255,  EE ? 3 : 9, 0};

        rst = 1'b1; c0_start = 1'b0; c1_start = 1'b0;
        c0_a = '0; c0_b = '0; c1_a = '0; c1_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy0", c0_busy, 0);
        chk("reset_busy1", c1_busy, 0);
        chk("reset_y0", c0_y, 0);
        chk("reset_y1", c1_y, 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c0_a = vecs[i].a0; c0_b = vecs[i].b0; c1_a = vecs[i].a1; c1_b = vecs[i].b1;
            c0_start = vecs[i].who[0]; c1_start = vecs[i].who[1];
            @(negedge clk);
            c0_start = 1'b0; c1_start = 1'b0;
            // operand noise while busy must not matter
            c0_a = W'($urandom); c0_b = W'($urandom); c1_a = W'($urandom); c1_b = W'($urandom);
            n0 = 0; n1 = 0; fin = 0;
            for (int k = 0; k < 60 && !fin; k++) begin
                if (c0_busy) n0++;
                if (c1_busy) n1++;
                if (!c0_busy && !c1_busy) fin = 1;
                else @(negedge clk);
            end
            if (!fin) chk($sformatf("vec%0d_timeout", i), 0, 1);
            chk($sformatf("vec%0d_y0", i), c0_y, vecs[i].y0);
            chk($sformatf("vec%0d_y1", i), c1_y, vecs[i].y1);
            chk($sformatf("vec%0d_busy0_cycles", i), n0, vecs[i].bz0);
            chk($sformatf("vec%0d_busy1_cycles", i), n1, vecs[i].bz1);
        end

        // Start held high with new operands through the whole busy window.
        @(negedge clk);
        c0_a = 8'd7; c0_b = 8'd9; c0_start = 1'b1;
        @(negedge clk);
        c0_a = 8'd1; c0_b = 8'd1;
        n0 = 0;
        for (int k = 0; k < 60; k++) begin
            if (!c0_busy) break;
            n0++;
            @(negedge clk);
        end
        c0_start = 1'b0;
        chk("hold_busy_cycles", n0, EE ? 5 : 9);
        chk("hold_y0", c0_y, 63);
        repeat (12) @(negedge clk);
        chk("hold_no_second_op", c0_busy, 0);
        chk("hold_y0_stable", c0_y, 63);

        // Reset in the middle of an operation.
        @(negedge clk);
        c0_a = 8'd200; c0_b = 8'd200; c0_start = 1'b1;
        @(negedge clk);
        c0_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy0", c0_busy, 0);
        chk("abort_y0", c0_y, 0);
        chk("abort_y1", c1_y, 0);
        repeat (15) @(negedge clk);
        chk("abort_busy0_late", c0_busy, 0);
        chk("abort_y0_late", c0_y, 0);

        // Reset wins over starts on the same edge.
        rst = 1'b1; c0_start = 1'b1; c1_start = 1'b1;
        @(negedge clk);
        rst = 1'b0; c0_start = 1'b0; c1_start = 1'b0;
        chk("rstprio_busy0", c0_busy, 0);
        chk("rstprio_busy1", c1_busy, 0);
        @(negedge clk);
        chk("rstprio_busy0_next", c0_busy, 0);
        chk("rstprio_busy1_next", c1_busy, 0);

        // Randomized traffic against the reference model.
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            chk("rnd_busy0", c0_busy, m_busy[0]);
            chk("rnd_busy1", c1_busy, m_busy[1]);
            chk("rnd_y0", c0_y, m_y[0]);
            chk("rnd_y1", c1_y, m_y[1]);
            rst      = ($urandom_range(0, 249) == 0);
            c0_start = ($urandom_range(0, 2) == 0);
            c1_start = ($urandom_range(0, 2) == 0);
            c0_a = W'($urandom);
            c1_a = W'($urandom);
            c0_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            c1_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_shared.md
MUL_SHARED -- requirements
Module: mul_shared

Interface
REQ-001 SHALL have parameter: W, default 8, operand width; result width is 2*W.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: c0_a_bi  input  W  client 0 multiplicand.
REQ-005 SHALL have port: c0_b_bi  input  W  client 0 multiplier.
REQ-006 SHALL have port: c0_start_i  input  1  client 0 request strobe.
REQ-007 SHALL have port: c0_busy_o  output  1  client 0 request accepted, result not yet written.
REQ-008 SHALL have port: c0_y_bo  output  2*W  client 0 product, held between results.
REQ-009 SHALL have ports c1_a_bi, c1_b_bi, c1_start_i, c1_busy_o, c1_y_bo, identical to REQ-004..008, for client 1.

Function
REQ-010 SHALL act as responder to two multiplier-protocol initiators, sharing one internal shift-add engine.
REQ-011 SHALL sample cN_start_i only while cN_busy_o=0; on a sampling edge with start=1, latch operands and set cN_busy_o=1 after that edge.
REQ-012 SHALL ignore cN_start_i and operand changes while cN_busy_o=1.
REQ-013 SHALL run engine FSM: IDLE -> MUL on the edge after any pending client exists; MUL -> IDLE on completion edge.
REQ-014 SHALL, on the IDLE->MUL edge, load the granted client's latched operands, clear the accumulator, and clear the iteration counter.
REQ-015 SHALL, per MUL cycle, add the shifted multiplicand to the accumulator when the multiplier LSB=1, then shift multiplicand left and multiplier right.
REQ-016 SHALL execute exactly W iterations in MUL (macro absent).
REQ-017 SHALL, on the completion edge, write the full 2*W-bit product to the granted client's y_bo and clear its busy_o on that same edge; no truncation or overflow possible.
REQ-018 SHALL yield uncontended latency: busy_o high for W+1 cycles (9 for W=8), with y_bo valid when busy_o falls.
REQ-019 SHALL arbitrate round-robin when both clients are pending in IDLE: grant the client not served last.
REQ-020 SHALL, on simultaneous starts, accept both on the same edge. The first-granted client SHALL see W+1 busy cycles; the second SHALL see 2*W+2.
REQ-021 SHALL NOT update cN_y_bo except on that client's completion edge.
REQ-022 SHALL allow a client to issue a new start on the cycle after its busy_o falls.
REQ-023 SHALL let a new start from the non-granted client be accepted during MUL and held pending without disturbing the running operation.

Reset
REQ-024 SHALL, with rst_i=1 at an edge, force c0_busy_o=0, c1_busy_o=0, c0_y_bo=0, c1_y_bo=0, engine IDLE, latched operands 0, and last-served=client 1 (client 0 wins first tie).
REQ-025 SHALL abort any in-flight or pending operation on reset, writing no result.
REQ-026 SHALL give rst_i priority over starts sampled on the same edge.

Configuration
REQ-027 SHALL recognise macro MUL_SHARED_EARLY_EXIT_EN.
REQ-028 With MUL_SHARED_EARLY_EXIT_EN defined, SHALL complete MUL on the first iteration edge after which the remaining multiplier is zero (minimum 1 iteration, maximum W). busy_o duration SHALL then be iterations+1 cycles.
REQ-029 Without MUL_SHARED_EARLY_EXIT_EN, SHALL use fixed W-iteration latency per REQ-016. Products SHALL be identical in both builds.

Verification
REQ-030 Reset, then c0 start a=0 b=0 -> c0_busy_o high 9 cycles, c0_y_bo=0, c1_busy_o stays 0.
REQ-031 c0 start 255*255, then c1 start 54*54 after c0 done -> c0_y_bo=65025, c1_y_bo=2916, each busy 9 cycles.
REQ-032 Same-edge starts c0 12*13, c1 200*3 -> c0_y_bo=156 after 9 cycles; c1_y_bo=600 after 18 cycles. Next same-edge pair -> c1 served first.
REQ-033 c0 start 7*9, then c0_start_i=1 with a=1 b=1 held during busy -> c0_y_bo=63, no second operation.
REQ-034 rst_i pulse 4 cycles into a c0 200*200 operation -> busy 0, y_bo 0, no later result write.
REQ-035 With MUL_SHARED_EARLY_EXIT_EN: c0 54*2 -> c0_y_bo=108, busy 3 cycles; 0*0 -> busy 2 cycles.
